pc_seq: RTL and testbench
=========================

PC_SEQ -- requirements
Module: pc_seq

Interface
REQ-001 The block SHALL have parameter ADDR_W, default 8, meaning program-address width in bits.
REQ-002 The block SHALL have parameter OFF_W, default 5, meaning width of the signed relative-branch offset (OFF_W <= ADDR_W).
REQ-003 The block SHALL have parameter STACK_DEPTH, default 4, meaning number of return-address entries (>= 2).
REQ-004 The block SHALL have parameter RESET_VEC, default 0, meaning the address loaded on reset.
REQ-005 The block SHALL have port clk  input  1  single clock; all state updates on its rising edge.
REQ-006 The block SHALL have port rst  input  1  asynchronous, active-low reset.
REQ-007 The block SHALL have port stall  input  1  hold all state this cycle.
REQ-008 The block SHALL have port jump  input  1  absolute jump to jumpaddr.
REQ-009 The block SHALL have port jumpaddr  input  ADDR_W  absolute target for jump and call.
REQ-010 The block SHALL have port branch  input  1  relative branch by br_off.
REQ-011 The block SHALL have port br_off  input  OFF_W  signed two's-complement offset.
REQ-012 The block SHALL have port call  input  1  push return address, go to jumpaddr.
REQ-013 The block SHALL have port ret  input  1  pop return address into PC.
REQ-014 The block SHALL have port err_clr  input  1  clear sticky error flags.
REQ-015 The block SHALL have port addr  output  ADDR_W  current program counter, registered.
REQ-016 The block SHALL have ports stack_empty and stack_full  output  1 each  stack occupancy flags, combinational from the count.
REQ-017 The block SHALL have ports ovf and unf  output  1 each  sticky overflow/underflow flags.

Function
REQ-018 Per rising edge, the block SHALL apply exactly one action, by priority: stall > ret > call > jump > branch > increment.
REQ-019 On stall, the block SHALL leave PC, stack, count and flags unchanged; err_clr still acts.
REQ-020 On increment, PC SHALL become PC+1 modulo 2^ADDR_W (max value wraps to 0).
REQ-021 On jump, PC SHALL become jumpaddr.
REQ-022 On branch, PC SHALL become PC + sign-extended br_off, modulo 2^ADDR_W; the offset is relative to the current PC, not PC+1.
REQ-023 On call with the stack not full, PC+1 (wrapped) SHALL be pushed, count incremented, and PC SHALL become jumpaddr.
REQ-024 On call with the stack full, PC SHALL still become jumpaddr, the push and count SHALL be suppressed, and ovf SHALL be set.
REQ-025 On ret with the stack not empty, PC SHALL become the top entry and count SHALL decrement.
REQ-026 On ret with the stack empty, the block SHALL increment PC and set unf.
REQ-027 addr SHALL reflect each action's result one cycle after the edge; there is no combinational path from inputs to addr.
REQ-028 err_clr SHALL clear ovf and unf on the edge; a same-cycle set SHALL take precedence over the clear.
REQ-029 stack_full SHALL be high when count == STACK_DEPTH, and stack_empty when count == 0.

Reset
REQ-030 While rst is low, the block SHALL asynchronously force addr=RESET_VEC, count=0, ovf=0 and unf=0; stack contents are don't-care.
REQ-031 After rst deasserts, the first rising edge SHALL perform a normal prioritised action.
REQ-032 A reset asserted mid-call/ret SHALL discard the in-flight action.

Structure
REQ-033 A shared package SHALL hold the action-priority enum (HOLD, RET, CALL, JUMP, BRANCH, INC) and the default parameter constants.
REQ-034 The return stack SHALL be a sub-module, pc_ret_stack (LIFO with push, pop, top, count, full, empty, parametrised by ADDR_W and STACK_DEPTH).
REQ-035 The next-PC selection SHALL be a single combinational mux driven by the decoded action.

Verification
REQ-036 The bench SHALL check: reset, then 260 increment cycles (ADDR_W=8) -> addr counts 0..255, wraps to 0, and reaches 3 at cycle 260.
REQ-037 The bench SHALL check: at addr=0x10, branch with br_off=-3 (5'b11101) -> addr=0x0D; at addr=0x02, br_off=-5 -> addr=0xFD.
REQ-038 The bench SHALL check: at addr=0x20, call to 0x80, then ret next cycle -> addr goes 0x80 then 0x21; count goes 1 then 0.
REQ-039 The bench SHALL check: 5 nested calls with STACK_DEPTH=4 -> 5th jump is taken, ovf=1, stack_full=1; 4 rets return the correct LIFO addresses; a 5th ret increments PC and sets unf=1.
REQ-040 The bench SHALL check: stall+call+jump asserted together -> addr, count and flags hold; after stall drops, call wins over jump.
REQ-041 The bench SHALL check: rst pulsed low between clock edges during a call -> addr=RESET_VEC immediately; count=0, ovf=0 and unf=0 without waiting for a clock edge.

Source files
------------

// File: rtl/pc_seq_pkg.sv
// Shared types and default parameters for the program-counter sequencer.
// The action enum lists actions in decreasing priority.
package pc_seq_pkg;

  typedef enum logic [2:0] {
    ActHold,
    ActRet,
    ActCall,
    ActJump,
    ActBranch,
    ActInc
  } action_e;

  localparam int unsigned DefAddrW      = 8;
  localparam int unsigned DefOffW       = 5;
  localparam int unsigned DefStackDepth = 4;
  localparam int unsigned DefResetVec   = 0;

endpackage

// File: rtl/pc_ret_stack.sv
// LIFO of return addresses. Pushes when full and pops when empty are ignored,
// so the caller can raise push/pop unconditionally and read the flags.
module pc_ret_stack
  import pc_seq_pkg::*;
#(
  parameter int unsigned ADDR_W      = DefAddrW,
  parameter int unsigned STACK_DEPTH = DefStackDepth,
  localparam int unsigned CntW       = $clog2(STACK_DEPTH + 1)
) (
  input  logic              clk,
  input  logic              rst,
  input  logic              push,
  input  logic              pop,
  input  logic [ADDR_W-1:0] din,
  output logic [ADDR_W-1:0] top,
  output logic [CntW-1:0]   count,
  output logic              full,
  output logic              empty
);

  localparam int unsigned PtrW = $clog2(STACK_DEPTH);

  logic [ADDR_W-1:0] mem_q [STACK_DEPTH];
  logic [CntW-1:0]   cnt_q, cnt_d;
  logic [PtrW-1:0]   wr_ptr, top_ptr;
  logic              do_push, do_pop;

  assign full    = (cnt_q == CntW'(STACK_DEPTH));
  assign empty   = (cnt_q == '0);
  assign do_push = push & ~full;
  assign do_pop  = pop & ~empty;
  assign wr_ptr  = PtrW'(cnt_q);
  assign top_ptr = PtrW'(cnt_q - CntW'(1));
  // Value is meaningless while empty; the consumer must check empty first.
  assign top     = mem_q[top_ptr];
  assign count   = cnt_q;

  always_comb begin
    cnt_d = cnt_q;
    if (do_push) begin
      cnt_d = cnt_q + CntW'(1);
    end else if (do_pop) begin
      cnt_d = cnt_q - CntW'(1);
    end
  end

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      cnt_q <= '0;
    end else begin
      cnt_q <= cnt_d;
    end
  end

  // Entries need no reset: they are only read below the count.
  always_ff @(posedge clk) begin
    if (do_push) begin
      mem_q[wr_ptr] <= din;
    end
  end

endmodule

// File: rtl/pc_seq.sv
// Program-counter sequencer: one prioritised action per clock
// (hold, return, call, jump, relative branch, increment) with a return stack.
module pc_seq
  import pc_seq_pkg::*;
#(
  parameter int unsigned ADDR_W      = DefAddrW,
  parameter int unsigned OFF_W       = DefOffW,
  parameter int unsigned STACK_DEPTH = DefStackDepth,
  parameter int unsigned RESET_VEC   = DefResetVec
) (
  input  logic              clk,
  input  logic              rst,
  input  logic              stall,
  input  logic              jump,
  input  logic [ADDR_W-1:0] jumpaddr,
  input  logic              branch,
  input  logic [OFF_W-1:0]  br_off,
  input  logic              call,
  input  logic              ret,
  input  logic              err_clr,
  output logic [ADDR_W-1:0] addr,
  output logic              stack_empty,
  output logic              stack_full,
  output logic              ovf,
  output logic              unf
);

  localparam int unsigned CntW = $clog2(STACK_DEPTH + 1);

  action_e           act;
  logic [ADDR_W-1:0] pc_q, pc_d, pc_inc, off_ext, stk_top;
  logic [CntW-1:0]   stk_count;
  logic              ovf_q, ovf_d, unf_q, unf_d;
  logic              set_ovf, set_unf;

  always_comb begin
    act = ActInc;
    if (stall) begin
      act = ActHold;
    end else if (ret) begin
      act = ActRet;
    end else if (call) begin
      act = ActCall;
    end else if (jump) begin
      act = ActJump;
    end else if (branch) begin
      act = ActBranch;
    end
  end

  assign pc_inc  = pc_q + ADDR_W'(1);
  // Size cast of a signed operand sign-extends the offset.
  assign off_ext = ADDR_W'($signed(br_off));

  always_comb begin
    pc_d = pc_inc;
    unique case (act)
      ActHold:          pc_d = pc_q;
      ActRet:           pc_d = stack_empty ? pc_inc : stk_top;
      ActCall, ActJump: pc_d = jumpaddr;
      ActBranch:        pc_d = pc_q + off_ext;
      ActInc:           pc_d = pc_inc;
      default:          pc_d = pc_inc;
    endcase
  end

  assign set_ovf = (act == ActCall) && (stk_count == CntW'(STACK_DEPTH));
  assign set_unf = (act == ActRet) && stack_empty;
  // A set in the same cycle wins over err_clr.
  assign ovf_d   = (ovf_q & ~err_clr) | set_ovf;
  assign unf_d   = (unf_q & ~err_clr) | set_unf;

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      pc_q  <= ADDR_W'(RESET_VEC);
      ovf_q <= 1'b0;
      unf_q <= 1'b0;
    end else begin
      pc_q  <= pc_d;
      ovf_q <= ovf_d;
      unf_q <= unf_d;
    end
  end

  pc_ret_stack #(
    .ADDR_W      (ADDR_W),
    .STACK_DEPTH (STACK_DEPTH)
  ) u_stack (
    .clk   (clk),
    .rst   (rst),
    .push  (act == ActCall),
    .pop   (act == ActRet),
    .din   (pc_inc),
    .top   (stk_top),
    .count (stk_count),
    .full  (stack_full),
    .empty (stack_empty)
  );

  assign addr = pc_q;
  assign ovf  = ovf_q;
  assign unf  = unf_q;

endmodule

// File: tb/tb_pc_seq.sv
// Scoreboard bench for pc_seq: a behavioural model queues the expected state
// for each driven cycle and a monitor compares it after the clock edge.
module tb_pc_seq;

  localparam int unsigned AW = 8;
  localparam int unsigned OW = 5;
  localparam int unsigned SD = 4;

  logic          clk = 1'b0;
  logic          rst = 1'b0;
  logic          stall = 1'b1, jump = 1'b0, branch = 1'b0, call = 1'b0, ret = 1'b0;
  logic          err_clr = 1'b0;
  logic [AW-1:0] jumpaddr = '0;
  logic [OW-1:0] br_off = '0;
  logic [AW-1:0] addr;
  logic          stack_empty, stack_full, ovf, unf;

  int n_checks = 0;
  int n_errors = 0;

  typedef struct {
    string      tag;
    logic [7:0] addr;
    int         cnt;
    bit         ovf;
    bit         unf;
  } exp_t;

  exp_t       sb[$];
  exp_t       e;
  logic [7:0] m_pc;
  logic [7:0] m_stk[$];
  bit         m_ovf, m_unf;
  logic [7:0] ret_exp [4] = '{8'h71, 8'h61, 8'h51, 8'h41};
  logic [7:0] call_tgt [5] = '{8'h50, 8'h60, 8'h70, 8'h90, 8'hA0};

  always #5 clk = ~clk;

  pc_seq #(
    .ADDR_W      (AW),
    .OFF_W       (OW),
    .STACK_DEPTH (SD),
    .RESET_VEC   (0)
  ) dut (
    .clk         (clk),
    .rst         (rst),
    .stall       (stall),
    .jump        (jump),
    .jumpaddr    (jumpaddr),
    .branch      (branch),
    .br_off      (br_off),
    .call        (call),
    .ret         (ret),
    .err_clr     (err_clr),
    .addr        (addr),
    .stack_empty (stack_empty),
    .stack_full  (stack_full),
    .ovf         (ovf),
    .unf         (unf)
  );

  task automatic check_eq(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_checks++;
    if (got !== exp) begin
      n_errors++;
      $display("FAIL %s: got 0x%0h expected 0x%0h", tag, got, exp);
    end
  endtask

  task automatic m_reset();
    m_pc  = 8'h00;
    m_stk.delete();
    m_ovf = 1'b0;
    m_unf = 1'b0;
  endtask

  // Drive one cycle of controls and queue the model's post-edge state.
  task automatic cyc(input string tag, input bit st, input bit rt, input bit cl, input bit jp,
                     input bit br, input logic [7:0] ja, input logic [4:0] off, input bit ec);
    bit so, su;
    so = 1'b0;
    su = 1'b0;
    @(negedge clk);
    stall = st; ret = rt; call = cl; jump = jp; branch = br;
    jumpaddr = ja; br_off = off; err_clr = ec;
    if (!st) begin
      if (rt) begin
        if (m_stk.size() != 0) m_pc = m_stk.pop_back();
        else begin
          m_pc = m_pc + 8'd1;
          su = 1'b1;
        end
      end else if (cl) begin
        if (m_stk.size() < int'(SD)) m_stk.push_back(m_pc + 8'd1);
        else so = 1'b1;
        m_pc = ja;
      end else if (jp) begin
        m_pc = ja;
      end else if (br) begin
        m_pc = m_pc + {{3{off[4]}}, off};
      end else begin
        m_pc = m_pc + 8'd1;
      end
    end
    if (ec) begin
      m_ovf = 1'b0;
      m_unf = 1'b0;
    end
    if (so) m_ovf = 1'b1;
    if (su) m_unf = 1'b1;
    sb.push_back('{tag, m_pc, m_stk.size(), m_ovf, m_unf});
  endtask

  task automatic wait_edge();
    @(posedge clk);
    #2;
  endtask

  initial begin
    forever begin
      @(posedge clk);
      #1;
      if (sb.size() != 0) begin
        e = sb.pop_front();
        check_eq({e.tag, ".addr"}, 32'(addr), 32'(e.addr));
        check_eq({e.tag, ".count"}, 32'(dut.u_stack.count), 32'(e.cnt));
        check_eq({e.tag, ".empty"}, 32'(stack_empty), 32'(e.cnt == 0));
        check_eq({e.tag, ".full"}, 32'(stack_full), 32'(e.cnt == int'(SD)));
        check_eq({e.tag, ".ovf"}, 32'(ovf), 32'(e.ovf));
        check_eq({e.tag, ".unf"}, 32'(unf), 32'(e.unf));
      end
    end
  end

  initial begin
    #100000;
    $display("FAIL watchdog: got timeout expected completion");
    $fatal(1, "watchdog expired");
  end

  initial begin
    m_reset();
    #3;
    check_eq("rst.addr", 32'(addr), 32'd0);
    check_eq("rst.count", 32'(dut.u_stack.count), 32'd0);
    check_eq("rst.empty", 32'(stack_empty), 32'd1);
    check_eq("rst.full", 32'(stack_full), 32'd0);
    check_eq("rst.ovf", 32'(ovf), 32'd0);
    check_eq("rst.unf", 32'(unf), 32'd0);
    @(negedge clk);
    rst = 1'b1;

    // Increment across the wrap; the 259th edge leaves addr at 3.
    for (int i = 1; i <= 259; i++) begin
      cyc($sformatf("inc%0d", i), 0, 0, 0, 0, 0, 8'h00, 5'd0, 0);
      if (i == 255 || i == 256 || i == 259) begin
        wait_edge();
        check_eq($sformatf("wrap%0d", i), 32'(addr),
                 (i == 255) ? 32'd255 : (i == 256) ? 32'd0 : 32'd3);
      end
    end

    cyc("jmp10", 0, 0, 0, 1, 0, 8'h10, 5'd0, 0);
    cyc("br_m3", 0, 0, 0, 0, 1, 8'h00, 5'b11101, 0);
    wait_edge();
    check_eq("br_m3_abs", 32'(addr), 32'h0D);
    cyc("jmp02", 0, 0, 0, 1, 0, 8'h02, 5'd0, 0);
    cyc("br_m5", 0, 0, 0, 0, 1, 8'h00, 5'b11011, 0);
    wait_edge();
    check_eq("br_m5_abs", 32'(addr), 32'hFD);

    cyc("jmp20", 0, 0, 0, 1, 0, 8'h20, 5'd0, 0);
    cyc("call80", 0, 0, 1, 0, 0, 8'h80, 5'd0, 0);
    wait_edge();
    check_eq("call80_abs", 32'(addr), 32'h80);
    check_eq("call80_cnt", 32'(dut.u_stack.count), 32'd1);
    cyc("ret21", 0, 1, 0, 0, 0, 8'h00, 5'd0, 0);
    wait_edge();
    check_eq("ret21_abs", 32'(addr), 32'h21);
    check_eq("ret21_cnt", 32'(dut.u_stack.count), 32'd0);

    // Overflow then unwind to underflow.
    cyc("jmp40", 0, 0, 0, 1, 0, 8'h40, 5'd0, 0);
    for (int i = 0; i < 5; i++) cyc($sformatf("nest%0d", i), 0, 0, 1, 0, 0, call_tgt[i], 5'd0, 0);
    wait_edge();
    check_eq("ovf_abs.addr", 32'(addr), 32'hA0);
    check_eq("ovf_abs.ovf", 32'(ovf), 32'd1);
    check_eq("ovf_abs.full", 32'(stack_full), 32'd1);
    for (int i = 0; i < 4; i++) begin
      cyc($sformatf("unwind%0d", i), 0, 1, 0, 0, 0, 8'h00, 5'd0, 0);
      wait_edge();
      check_eq($sformatf("unwind%0d_abs", i), 32'(addr), 32'(ret_exp[i]));
    end
    cyc("ret_empty", 0, 1, 0, 0, 0, 8'h00, 5'd0, 0);
    wait_edge();
    check_eq("unf_abs.addr", 32'(addr), 32'h42);
    check_eq("unf_abs.unf", 32'(unf), 32'd1);

    // Stall dominates call and jump; then call beats jump.
    cyc("callC0", 0, 0, 1, 0, 0, 8'hC0, 5'd0, 0);
    cyc("stall_all", 1, 0, 1, 1, 0, 8'hE0, 5'd0, 0);
    cyc("call_wins", 0, 0, 1, 1, 0, 8'hE0, 5'd0, 0);
    wait_edge();
    check_eq("call_wins_cnt", 32'(dut.u_stack.count), 32'd2);
    cyc("retC1", 0, 1, 0, 0, 0, 8'h00, 5'd0, 0);
    cyc("stall_clr", 1, 0, 0, 0, 0, 8'h00, 5'd0, 1);
    cyc("ret43", 0, 1, 0, 0, 0, 8'h00, 5'd0, 0);
    cyc("ret_clr_set", 0, 1, 0, 0, 0, 8'h00, 5'd0, 1);
    wait_edge();
    check_eq("set_beats_clr", 32'(unf), 32'd1);

    // Asynchronous reset in the middle of a call.
    cyc("callB0", 0, 0, 1, 0, 0, 8'hB0, 5'd0, 0);
    @(negedge clk);
    stall = 1'b0; call = 1'b1; jumpaddr = 8'h77; err_clr = 1'b0; ret = 1'b0;
    #2;
    rst = 1'b0;
    #1;
    check_eq("arst.addr", 32'(addr), 32'd0);
    check_eq("arst.count", 32'(dut.u_stack.count), 32'd0);
    check_eq("arst.empty", 32'(stack_empty), 32'd1);
    check_eq("arst.ovf", 32'(ovf), 32'd0);
    check_eq("arst.unf", 32'(unf), 32'd0);
    wait_edge();
    check_eq("arst_hold.addr", 32'(addr), 32'd0);
    @(negedge clk);
    stall = 1'b1; call = 1'b0;
    rst = 1'b1;
    m_reset();
    cyc("post_rst_inc", 0, 0, 0, 0, 0, 8'h00, 5'd0, 0);
    wait_edge();
    check_eq("post_rst_abs", 32'(addr), 32'd1);

    for (int i = 0; i < 60; i++) begin
      cyc($sformatf("rnd%0d", i), $urandom_range(0, 5) == 0, $urandom_range(0, 3) == 0,
          $urandom_range(0, 3) == 0, $urandom_range(0, 3) == 0, $urandom_range(0, 2) == 0,
          8'($urandom), 5'($urandom), $urandom_range(0, 6) == 0);
    end

    @(negedge clk);
    check_eq("sb_drain", 32'(sb.size()), 32'd0);
    $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
    $finish;
  end

endmodule
